// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller:
// the FSM state encoding and the operand-forwarding select codes.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXE   = 2'b01;
    localparam logic [1:0] FWD_MEM   = 2'b10;
    localparam logic [1:0] FWD_MEMLD = 2'b11;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Picks the operand source for one ID-stage source register.
// The youngest producer wins: EX first, then MEM.
module pipe_fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       ex_wreg,
    input  logic       ex_m2reg,
    input  logic [4:0] ex_rn,
    input  logic       mem_wreg,
    input  logic       mem_m2reg,
    input  logic [4:0] mem_rn,
    output logic [1:0] sel
);

    // A load in EX has no data yet; that case is left to the load-use stall.
    always_comb begin
        sel = FWD_RF;
        if (ex_wreg && !ex_m2reg && ex_rn != 5'd0 && ex_rn == src) begin
            sel = FWD_EXE;
        end else if (mem_wreg && mem_rn != 5'd0 && mem_rn == src) begin
            sel = mem_m2reg ? FWD_MEMLD : FWD_MEM;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a five-stage pipeline: memory-wait FSM, branch
// and load-use handling, forwarding selects and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             ex_wreg,
    input  logic             ex_m2reg,
    input  logic [4:0]       ex_rn,
    input  logic             ex_branch_taken,
    input  logic             mem_wreg,
    input  logic             mem_m2reg,
    input  logic [4:0]       mem_rn,
    input  logic             mem_access,
    input  logic             dmem_ack,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             mw_kill,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state;
    state_t next_state;
    logic   waiting;
    logic   mem_stall;
    logic   load_use;

    // While reset is held the controller behaves as an idle RUN state.
    assign waiting   = resetn && (state == MEM_WAIT);
    assign mem_stall = resetn && !dmem_ack && (waiting || mem_access);
    assign dmem_req  = waiting || mem_access;
    assign load_use  = ex_wreg && ex_m2reg && (ex_rn != 5'd0) &&
                       ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));

    always_comb begin
        next_state = state;
        case (state)
            RUN:      next_state = (mem_access && !dmem_ack) ? MEM_WAIT : RUN;
            MEM_WAIT: next_state = dmem_ack ? RUN : MEM_WAIT;
            default:  next_state = RUN;
        endcase
    end

    always_comb begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        mw_kill    = 1'b0;
        if (!resetn) begin
            pc_en = 1'b1;
        end else if (mem_stall) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            mw_kill  = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= RUN;
            stall_cnt <= '0;
        end else begin
            state <= next_state;
            if (!pc_en && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
        end
    end

    pipe_fwd_sel u_fwd_rs (
        .src       (id_rs),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .ex_rn     (ex_rn),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_rn    (mem_rn),
        .sel       (fwd_a)
    );

    pipe_fwd_sel u_fwd_rt (
        .src       (id_rt),
        .ex_wreg   (ex_wreg),
        .ex_m2reg  (ex_m2reg),
        .ex_rn     (ex_rn),
        .mem_wreg  (mem_wreg),
        .mem_m2reg (mem_m2reg),
        .mem_rn    (mem_rn),
        .sel       (fwd_b)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// checked every cycle against a rule-level model (16-bit and 4-bit counters).
module tb_pipe_hazard_ctrl;

    logic        clock = 1'b0;
    logic        resetn;
    logic [4:0]  id_rs, id_rt, ex_rn, mem_rn;
    logic        id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_branch_taken;
    logic        mem_wreg, mem_m2reg, mem_access, dmem_ack;
    logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en;
    logic        ifid_flush, idex_flush, mw_kill;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;
    logic        dmem_req4, pc_en4, ifid_en4, idex_en4, exmem_en4;
    logic        ifid_flush4, idex_flush4, mw_kill4;
    logic [1:0]  fwd_a4, fwd_b4;
    logic [3:0]  stall_cnt4;

    int checks = 0;
    int failures = 0;

    // Reference model: whether an access is outstanding and the stall totals.
    bit mdl_waiting = 0;
    int mdl_cnt = 0;
    int mdl_cnt4 = 0;
    logic [7:0] exp_ctrl;
    logic [1:0] exp_fa, exp_fb;

    always #5 clock = ~clock;

    pipe_hazard_ctrl #(.CNT_W(16)) dut (
        .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_branch_taken(ex_branch_taken),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .mw_kill(mw_kill),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4)) dut4 (
        .clock(clock), .resetn(resetn), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_wreg(ex_wreg),
        .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_branch_taken(ex_branch_taken),
        .mem_wreg(mem_wreg), .mem_m2reg(mem_m2reg), .mem_rn(mem_rn),
        .mem_access(mem_access), .dmem_ack(dmem_ack), .dmem_req(dmem_req4),
        .pc_en(pc_en4), .ifid_en(ifid_en4), .idex_en(idex_en4), .exmem_en(exmem_en4),
        .ifid_flush(ifid_flush4), .idex_flush(idex_flush4), .mw_kill(mw_kill4),
        .fwd_a(fwd_a4), .fwd_b(fwd_b4), .stall_cnt(stall_cnt4)
    );

    function automatic logic [1:0] modelFwd(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (ex_wreg && !ex_m2reg && ex_rn == src) return 2'b01;
        if (mem_wreg && mem_rn == src) return mem_m2reg ? 2'b11 : 2'b10;
        return 2'b00;
    endfunction

    // ctrl order: pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mw_kill, dmem_req
    task automatic computeExpected();
        bit memory_stall, load_hazard, req;
        memory_stall = resetn && !dmem_ack && (mdl_waiting || mem_access);
        load_hazard  = ex_wreg && ex_m2reg && ex_rn != 0 &&
                       ((id_use_rs && id_rs == ex_rn) || (id_use_rt && id_rt == ex_rn));
        req = mem_access || (resetn && mdl_waiting);
        if (!resetn)              exp_ctrl = {7'b1111_000, req};
        else if (memory_stall)    exp_ctrl = {7'b0000_001, req};
        else if (ex_branch_taken) exp_ctrl = {7'b1111_110, req};
        else if (load_hazard)     exp_ctrl = {7'b0011_010, req};
        else                      exp_ctrl = {7'b1111_000, req};
        exp_fa = modelFwd(id_rs);
        exp_fb = modelFwd(id_rt);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic setIdle();
        resetn = 1; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        ex_wreg = 0; ex_m2reg = 0; ex_rn = 0; ex_branch_taken = 0;
        mem_wreg = 0; mem_m2reg = 0; mem_rn = 0; mem_access = 0; dmem_ack = 0;
    endtask

    // Inputs are set before this call; it checks one cycle and advances the model.
    task automatic applyStimulus();
        #1;
        computeExpected();
        checkOutput("ctrl", {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, mw_kill, dmem_req}, exp_ctrl);
        checkOutput("ctrl4", {pc_en4, ifid_en4, idex_en4, exmem_en4, ifid_flush4, idex_flush4, mw_kill4, dmem_req4}, exp_ctrl);
        checkOutput("fwd_a", fwd_a, exp_fa);
        checkOutput("fwd_b", fwd_b, exp_fb);
        checkOutput("stall_cnt", stall_cnt, mdl_cnt);
        checkOutput("stall_cnt4", stall_cnt4, mdl_cnt4);
        @(posedge clock);
        if (!resetn) begin
            mdl_waiting = 0; mdl_cnt = 0; mdl_cnt4 = 0;
        end else begin
            if (!exp_ctrl[7]) begin
                if (mdl_cnt < 65535) mdl_cnt++;
                if (mdl_cnt4 < 15) mdl_cnt4++;
            end
            mdl_waiting = (mdl_waiting || mem_access) && !dmem_ack;
        end
        @(negedge clock);
    endtask

    initial begin
        $display("[TB] start");
        setIdle();
        resetn = 0;
        @(negedge clock);
        applyStimulus();
        applyStimulus();
        setIdle();
        applyStimulus();
        checkOutput("reset_cnt", stall_cnt, 16'd0);

        // Load-use on rs: freeze PC/IFID, bubble into ID/EX
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 8; id_rs = 8; id_use_rs = 1;
        applyStimulus();
        checkOutput("lu_cnt", stall_cnt, 16'd1);
        // Same with a taken branch: branch wins, no stall
        ex_branch_taken = 1;
        applyStimulus();
        checkOutput("br_cnt", stall_cnt, 16'd1);

        // Memory access acked after three wait cycles
        setIdle();
        mem_access = 1;
        applyStimulus();
        mem_access = 0;
        applyStimulus();
        applyStimulus();
        dmem_ack = 1;
        applyStimulus();
        dmem_ack = 0;
        applyStimulus();
        checkOutput("mem_cnt", stall_cnt, 16'd4);

        // Forwarding priorities
        setIdle();
        ex_wreg = 1; mem_wreg = 1; ex_rn = 5; mem_rn = 5; id_rs = 5;
        applyStimulus();
        ex_wreg = 0; mem_m2reg = 1;
        applyStimulus();
        id_rs = 0; ex_rn = 0; mem_rn = 0;
        applyStimulus();

        // Reset while waiting on memory
        setIdle();
        mem_access = 1;
        applyStimulus();
        mem_access = 0;
        applyStimulus();
        resetn = 0;
        applyStimulus();
        resetn = 1;
        applyStimulus();
        mem_access = 1; dmem_ack = 1;
        applyStimulus();

        // Twenty load-use stalls saturate the 4-bit counter
        setIdle();
        ex_wreg = 1; ex_m2reg = 1; ex_rn = 3; id_rt = 3; id_use_rt = 1;
        for (int i = 0; i < 20; i++) applyStimulus();
        checkOutput("sat4", stall_cnt4, 4'd15);

        // Random traffic over a small register set to provoke matches
        for (int i = 0; i < 400; i++) begin
            resetn = ($urandom_range(0, 39) != 0);
            id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
            ex_rn = 5'($urandom_range(0, 3)); mem_rn = 5'($urandom_range(0, 3));
            id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
            ex_wreg = 1'($urandom); ex_m2reg = 1'($urandom);
            mem_wreg = 1'($urandom); mem_m2reg = 1'($urandom);
            ex_branch_taken = ($urandom_range(0, 4) == 0);
            mem_access = ($urandom_range(0, 2) == 0);
            dmem_ack = ($urandom_range(0, 2) == 0);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
